// File: rtl/cell_write_scheduler_pkg.sv
// rtl/cell_write_scheduler_pkg.sv - cell buffer geometry, types and scheduler state encoding
package cell_buffer_pkg;
    localparam int CELL_HORIZONTAL_LENGHT = 36;
    localparam int CELL_VERTICAL_LENGHT   = 20;
    localparam int CELL_COUNT             = CELL_HORIZONTAL_LENGHT * CELL_VERTICAL_LENGHT;
    localparam int CELL_ADDR_W            = $clog2(CELL_COUNT);

    typedef logic [7:0]             cell_char_t;
    typedef logic [CELL_ADDR_W-1:0] cell_addr_t;

    typedef enum logic {IDLE, FILL} sched_state_t;
    typedef enum logic {REQ_A, REQ_B} req_sel_t;

    localparam cell_addr_t LAST_ADDR = cell_addr_t'(CELL_COUNT - 1);

    function automatic logic addr_in_range(input cell_addr_t addr);
        return addr < cell_addr_t'(CELL_COUNT);
    endfunction
endpackage

// File: rtl/cell_write_scheduler_if.sv
// rtl/cell_write_scheduler_if.sv - requester, fill and cell-buffer write signals of the scheduler
interface cell_write_scheduler_if;
    import cell_buffer_pkg::*;

    logic       vblank;
    logic       a_valid;
    cell_addr_t a_addr;
    cell_char_t a_data;
    logic       a_ready;
    logic       b_valid;
    cell_addr_t b_addr;
    cell_char_t b_data;
    logic       b_ready;
    logic       fill_start;
    cell_char_t fill_char;
    logic       fill_busy;
    logic       fill_done;
    logic       mem_we;
    cell_addr_t mem_addr;
    cell_char_t mem_data;
    logic       drop;

    modport slave (
        input  vblank, a_valid, a_addr, a_data, b_valid, b_addr, b_data, fill_start, fill_char,
        output a_ready, b_ready, fill_busy, fill_done, mem_we, mem_addr, mem_data, drop
    );

    modport master (
        output vblank, a_valid, a_addr, a_data, b_valid, b_addr, b_data, fill_start, fill_char,
        input  a_ready, b_ready, fill_busy, fill_done, mem_we, mem_addr, mem_data, drop
    );
endinterface

// File: rtl/cell_write_scheduler_fill.sv
// rtl/cell_write_scheduler_fill.sv - whole-screen fill engine: address counter, latched char, done pulse
module cell_fill_engine
    import cell_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_gate,
    input  cell_char_t i_char,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_we,
    output cell_addr_t o_addr,
    output cell_char_t o_data,
    output logic       o_last
);
    logic       r_active;
    logic       r_tail;
    logic       r_busy;
    logic       r_done;
    cell_addr_t r_cnt;
    cell_char_t r_char;

    assign o_we   = r_active && i_gate;
    assign o_addr = r_cnt;
    assign o_data = r_char;
    assign o_last = o_we && (r_cnt == LAST_ADDR);
    assign o_busy = r_busy;
    assign o_done = r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_tail   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_char   <= '0;
        end else begin
            // busy covers the cycle the last write is on the bus; done follows it
            r_tail <= o_last;
            r_done <= r_tail;
            if (i_start && !r_active) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
                r_char   <= i_char;
                r_busy   <= 1'b1;
            end else begin
                if (r_tail)
                    r_busy <= 1'b0;
                if (o_we) begin
                    if (o_last)
                        r_active <= 1'b0;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/cell_write_scheduler.sv
// rtl/cell_write_scheduler.sv - blanking-gated two-requester write arbiter with fill engine
// Optional build macro: CELL_WRITE_ANYTIME_EN removes the vblank gate.
module cell_write_scheduler
    import cell_buffer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    cell_write_scheduler_if.slave  bus
);
    logic         w_gate;
    sched_state_t r_state;
    sched_state_t w_state_next;
    req_sel_t     r_ptr;
    logic         w_a_grant;
    logic         w_b_grant;
    logic         w_fill_go;
    logic         w_fill_we;
    logic         w_fill_last;
    cell_addr_t   w_fill_addr;
    cell_char_t   w_fill_data;
    cell_addr_t   w_req_addr;
    cell_char_t   w_req_data;
    logic         r_we;
    logic         r_drop;
    cell_addr_t   r_addr;
    cell_char_t   r_data;

`ifdef CELL_WRITE_ANYTIME_EN
    assign w_gate = 1'b1;
`else
    assign w_gate = bus.vblank;
`endif

    assign w_fill_go = rst && (r_state == IDLE) && bus.fill_start;

    cell_fill_engine u_fill (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_fill_go),
        .i_gate  (w_gate),
        .i_char  (bus.fill_char),
        .o_busy  (bus.fill_busy),
        .o_done  (bus.fill_done),
        .o_we    (w_fill_we),
        .o_addr  (w_fill_addr),
        .o_data  (w_fill_data),
        .o_last  (w_fill_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_a_grant    = 1'b0;
        w_b_grant    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fill_go)
                    w_state_next = FILL;
                else if (rst && w_gate) begin
                    w_a_grant = bus.a_valid && (!bus.b_valid || r_ptr == REQ_A);
                    w_b_grant = bus.b_valid && (!bus.a_valid || r_ptr == REQ_B);
                end
            end
            FILL: begin
                if (w_fill_last)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.a_ready = w_a_grant;
    assign bus.b_ready = w_b_grant;
    assign w_req_addr  = w_a_grant ? bus.a_addr : bus.b_addr;
    assign w_req_data  = w_a_grant ? bus.a_data : bus.b_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= REQ_A;
            r_we    <= 1'b0;
            r_drop  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_a_grant)
                r_ptr <= REQ_B;
            else if (w_b_grant)
                r_ptr <= REQ_A;
            r_we   <= 1'b0;
            r_drop <= 1'b0;
            if (w_fill_we) begin
                r_we   <= 1'b1;
                r_addr <= w_fill_addr;
                r_data <= w_fill_data;
            end else if (w_a_grant || w_b_grant) begin
                // out-of-range requests are consumed but never reach the buffer
                if (addr_in_range(w_req_addr)) begin
                    r_we   <= 1'b1;
                    r_addr <= w_req_addr;
                    r_data <= w_req_data;
                end else begin
                    r_drop <= 1'b1;
                end
            end
        end
    end

    assign bus.mem_we   = r_we;
    assign bus.mem_addr = r_addr;
    assign bus.mem_data = r_data;
    assign bus.drop     = r_drop;
endmodule

// File: doc/cell_write_scheduler.md
Name: cell_write_scheduler

Overview:
- Owns the single write port of the character-cell buffer that feeds vga_drawer.
- Shares that port between two requesters: A (game logic) and B (button/user input).
- Adds a built-in whole-screen fill engine.
- Commits writes only while the drawer reports vertical blanking, so no frame ever shows a half-updated buffer.
- Sits between the game FSMs and the cell array inside the top-level VGA controller.

Parameters:
- CELL_HORIZONTAL_LENGHT, 36, cells per row.
- CELL_VERTICAL_LENGHT, 20, cell rows.
- CELL_COUNT, CELL_HORIZONTAL_LENGHT*CELL_VERTICAL_LENGHT (720), total cells; derived, not overridden.

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain).
- rst  in  1  synchronous reset, active-low.
- vblank  in  1  high during the vertical blanking interval (from vga_drawer).
- a_valid  in  1  requester A has a write.
- a_addr  in  10  requester A cell index, row*CELL_HORIZONTAL_LENGHT+col.
- a_data  in  8  requester A ASCII code.
- a_ready  out  1  requester A write accepted this cycle.
- b_valid, b_addr, b_data, b_ready  same as A, for requester B.
- fill_start  in  1  one-cycle pulse: overwrite every cell with fill_char.
- fill_char  in  8  fill value; sampled on the fill_start cycle.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse after the last fill write.
- mem_we  out  1  cell buffer write enable.
- mem_addr  out  10  cell buffer address.
- mem_data  out  8  cell buffer data.
- drop  out  1  one-cycle pulse: an accepted request had addr >= CELL_COUNT.

Behaviour:
- Reset: rst low at a clk edge forces the following values on the next cycle:
  - mem_we=0, mem_addr=0, mem_data=0, fill_busy=0, fill_done=0, drop=0.
  - State = IDLE; round-robin pointer = A.
  - An in-progress fill is aborted with no further writes.
- a_ready and b_ready are combinational. Both are 0 while rst is low.
- State IDLE:
  - fill_start=1 → go to FILL and latch fill_char. Neither ready is asserted that cycle; fill wins over requests.
  - Otherwise, when vblank=1:
    - Only one valid → that requester gets ready=1.
    - Both valid → the requester the pointer selects gets ready=1.
    - After any grant the pointer moves to the other requester.
  - vblank=0 → both readies are 0 and requests wait. Requesters must hold valid, addr and data stable until ready.
- Accepted write: handshake = valid&&ready. On the next cycle, mem_we=1 with the captured addr/data (latency 1). One write per cycle at most; back-to-back grants are allowed.
- Out-of-range address (addr >= 720): the request is still accepted. Next cycle mem_we stays 0 and drop=1.
- State FILL:
  - fill_busy=1; an internal counter starts at 0.
  - Each cycle with vblank=1: mem_we=1, mem_addr=counter, mem_data=latched char, then counter increments.
  - vblank=0: mem_we=0 and the counter holds. The fill resumes in the next blanking interval.
  - The write to address 719 goes out on the same cycle as the return to IDLE.
  - The next cycle has fill_busy=0 and fill_done=1.
  - fill_start during FILL is ignored. Both readies are 0 throughout FILL.
- mem_we is 0 whenever no write is issued. mem_addr/mem_data hold their last values.

Optional Feature:
- CELL_WRITE_ANYTIME_EN defined: vblank gating is removed. Arbitration and fill proceed every cycle; a full fill takes exactly 720 cycles. Intended for simulation speed and for the debug overlay.
- Not defined: all writes are gated by vblank as described above.

Decomposition:
- Package cell_buffer_pkg holds:
  - CELL_COUNT and CELL_ADDR_W=$clog2(CELL_COUNT).
  - typedef cell_char_t = logic [7:0].
  - typedef cell_addr_t = logic [CELL_ADDR_W-1:0].
  - enum sched_state_t {IDLE, FILL}.
- Sub-module cell_fill_engine holds the counter, the latched char, the done pulse and the vblank pause.
- The top level keeps the arbiter and the output register.

Test Plan:
- vblank=1, only a_valid with addr 5, data 65 → a_ready=1 that cycle; next cycle mem_we=1, mem_addr=5, mem_data=65.
- vblank=1, A and B both valid for 4 cycles (A: addr 1, data 66; B: addr 2, data 67) → grants alternate A, B, A, B; mem_addr sequence 1, 2, 1, 2.
- b_valid held with vblank=0 for 100 cycles → b_ready=0 and no mem_we throughout; vblank rises → b_ready=1 on that cycle.
- fill_start with fill_char 0, vblank low after 300 writes and high again later → exactly 720 writes, addresses 0..719 with no gap or repeat; one fill_done pulse; readies stay 0 during the fill.
- a_valid with addr 720 while vblank=1 → a_ready=1; next cycle drop=1, mem_we=0.
- rst driven low after 50 fill writes → next cycle fill_busy=0, mem_we=0; no fill_done; a later fill_start restarts from address 0.
